ram_nr1w_sync: RTL and testbench

Parametrised synchronous main-memory model for the simulation SoC: NR independent read ports and one byte-masked write port over a register-array store, with valid/ready handshakes and one-cycle registered read latency. It replaces the helper-call-based dual-read RAM. Instruction fetch and LSU connect to separate read ports; the LSU also drives the write port. Out-of-window accesses are flagged instead of silently aliasing.

---
 rtl/ram_nr1w_sync.sv | 105 ++++++++++
 tb/tb_ram_nr1w_sync.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_nr1w_sync.sv
// Synchronous main-memory model: NR independent read ports with one-entry
// response registers, one byte-masked write port, address-window checking.
module ram_nr1w_sync #(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ADDR_W     = 64,
  parameter int unsigned       DEPTH_LOG2 = 16,
  parameter int unsigned       NR         = 2,
  parameter logic [ADDR_W-1:0] BASE       = ADDR_W'(64'h8000_0000)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NR-1:0]          rd_req_valid,
  output logic [NR-1:0]          rd_req_ready,
  input  logic [NR*ADDR_W-1:0]   rd_addr,
  output logic [NR-1:0]          rd_resp_valid,
  input  logic [NR-1:0]          rd_resp_ready,
  output logic [NR*DATA_W-1:0]   rd_resp_data,
  output logic [NR-1:0]          rd_resp_err,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W/8-1:0]    wr_mask,
  output logic                   wr_err
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SHIFT = $clog2(BYTES);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // The subtraction is done at full address width, so addresses below BASE
  // are rejected explicitly rather than wrapping into the window.
  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> (SHIFT + DEPTH_LOG2)) == '0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE) >> SHIFT;
    return DEPTH_LOG2'(off);
  endfunction

  logic                  wr_fire;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DATA_W-1:0]     wr_bmask;
  logic [DATA_W-1:0]     wr_merged;
  logic [NR-1:0]         rd_ok;
  logic [DATA_W-1:0]     rd_word [NR];

  assign wr_ready     = ~reset;
  assign rd_req_ready = ~rd_resp_valid | rd_resp_ready;

  // Byte-merged write word; also forwarded to same-index reads (write-first).
  always_comb begin
    wr_bmask = '0;
    for (int b = 0; b < BYTES; b++) begin
      wr_bmask[b*8 +: 8] = {8{wr_mask[b]}};
    end
    wr_fire   = wr_valid && !reset && in_window(wr_addr);
    wr_idx    = word_index(wr_addr);
    wr_merged = (mem[wr_idx] & ~wr_bmask) | (wr_data & wr_bmask);
  end

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      rd_ok[i]   = in_window(rd_addr[i*ADDR_W +: ADDR_W]);
      rd_word[i] = mem[word_index(rd_addr[i*ADDR_W +: ADDR_W])];
      if (wr_fire && (wr_idx == word_index(rd_addr[i*ADDR_W +: ADDR_W]))) begin
        rd_word[i] = wr_merged;
      end
    end
  end

  // Storage is deliberately not reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_idx] <= wr_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_resp_valid <= '0;
      rd_resp_err   <= '0;
      rd_resp_data  <= '0;
      wr_err        <= 1'b0;
    end else begin
      wr_err <= wr_valid && !in_window(wr_addr);
      for (int i = 0; i < NR; i++) begin
        if (rd_req_valid[i] && rd_req_ready[i]) begin
          rd_resp_valid[i]                <= 1'b1;
          rd_resp_err[i]                  <= ~rd_ok[i];
          rd_resp_data[i*DATA_W +: DATA_W] <= rd_ok[i] ? rd_word[i] : '0;
        end else if (rd_resp_ready[i]) begin
          rd_resp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_nr1w_sync.sv
// Scoreboard bench for ram_nr1w_sync: a byte-level memory model predicts each
// read response, queued per port at accept and compared while held/consumed.
module tb_ram_nr1w_sync;

  localparam int unsigned DW   = 64;
  localparam int unsigned AW   = 64;
  localparam int unsigned DL   = 16;
  localparam int unsigned NR   = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct {
    logic [63:0] d;
    logic        e;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     rd_req_valid;
  logic [NR-1:0]     rd_req_ready;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_resp_valid;
  logic [NR-1:0]     rd_resp_ready;
  logic [NR*DW-1:0]  rd_resp_data;
  logic [NR-1:0]     rd_resp_err;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_mask;
  logic              wr_err;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] model [int unsigned];

  ram_nr1w_sync #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(DL), .NR(NR), .BASE(BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic tb_in_win(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) < (64'd1 << (DL + 3)));
  endfunction

  function automatic int unsigned tb_idx(input logic [63:0] a);
    return 32'((a - BASE) >> 3);
  endfunction

  function automatic exp_t predict(input logic [63:0] a);
    exp_t r;
    r.e = !tb_in_win(a);
    r.d = 64'h0;
    if (!r.e) r.d = model.exists(tb_idx(a)) ? model[tb_idx(a)] : 'x;
    return r;
  endfunction

  // Evaluate one read port just before the rising edge.
  task automatic port_eval(input int p);
    int   n;
    exp_t e;
    n = (p == 0) ? q0.size() : q1.size();
    check($sformatf("rd_vld%0d", p), 64'(rd_resp_valid[p]), 64'(n != 0));
    check($sformatf("rd_rdy%0d", p), 64'(rd_req_ready[p]), 64'((n == 0) || rd_resp_ready[p]));
    if (n != 0) begin
      e = (p == 0) ? q0[0] : q1[0];
      check($sformatf("rd_data%0d", p), rd_resp_data[p*DW +: DW], e.d);
      check($sformatf("rd_err%0d", p), 64'(rd_resp_err[p]), 64'(e.e));
      if (rd_resp_ready[p]) begin
        if (p == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
    if (rd_req_valid[p] && ((n == 0) || rd_resp_ready[p])) begin
      e = predict(rd_addr[p*AW +: AW]);
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic        pend;
    logic [63:0] w;
    int unsigned k;
    #4;
    pend = 1'b0;
    if (!reset && wr_valid) begin
      if (tb_in_win(wr_addr)) begin
        k = tb_idx(wr_addr);
        w = model.exists(k) ? model[k] : 'x;
        for (int b = 0; b < 8; b++) if (wr_mask[b]) w[b*8 +: 8] = wr_data[b*8 +: 8];
        model[k] = w;
      end else begin
        pend = 1'b1;
      end
    end
    if (!reset) begin
      for (int p = 0; p < NR; p++) port_eval(p);
    end
    @(posedge clk);
    #1;
    check("wr_err", 64'(wr_err), 64'(pend));
    @(negedge clk);
  endtask

  task automatic idle();
    rd_req_valid = '0;
    wr_valid     = 1'b0;
  endtask

  task automatic rd(input int p, input logic [63:0] a);
    rd_req_valid[p]    = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] m);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_mask  = m;
  endtask

  initial begin
    reset         = 1'b1;
    rd_req_valid  = '0;
    rd_addr       = '0;
    rd_resp_ready = '1;
    wr_valid      = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    wr_mask       = '0;
    repeat (2) @(negedge clk);
    check("rst_vld",  64'(rd_resp_valid), 64'(0));
    check("rst_err",  64'(rd_resp_err), 64'(0));
    check("rst_d0",   rd_resp_data[63:0], 64'h0);
    check("rst_d1",   rd_resp_data[127:64], 64'h0);
    check("rst_wrdy", 64'(wr_ready), 64'(0));
    check("rst_werr", 64'(wr_err), 64'(0));
    reset = 1'b0;
    #1;
    check("rel_wrdy", 64'(wr_ready), 64'(1));
    check("rel_rrdy", 64'(rd_req_ready), 64'(2'b11));
    @(negedge clk);

    // Prefill words 0..7 so later reads have defined data.
    for (int k = 0; k < 8; k++) begin
      wr(BASE + 64'(k * 8), {32'hC0DE_0000 | 32'(k), 32'h5A5A_0000 | 32'(k)}, 8'hFF);
      step();
    end

    // Full write then read.
    idle(); wr(64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF); step();
    idle(); rd(0, 64'h8000_0008); step();
    idle(); step();
    check("t1_const", model[1], 64'h1122_3344_5566_7788);

    // Partial write, low four bytes.
    idle(); wr(64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F); step();
    idle(); rd(0, 64'h8000_0008); step();
    idle(); step();
    check("t2_const", model[1], 64'h1122_3344_BBBB_BBBB);

    // Same-cycle write and dual read of the same word, partial mask first.
    idle(); wr(64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
    rd(0, 64'h8000_0010); rd(1, 64'h8000_0010); step();
    idle(); wr(64'h8000_0010, 64'hDEAD_BEEF_0000_0001, 8'hFF);
    rd(0, 64'h8000_0010); rd(1, 64'h8000_0010); step();
    idle(); step();

    // Mask-zero write is a no-op.
    idle(); wr(64'h8000_0018, 64'h0, 8'h00); rd(1, 64'h8000_0018); step();
    idle(); step();

    // Window boundaries, out-of-window write must not alias onto the top word.
    idle(); wr(64'h8007_FFF8, 64'h0123_4567_89AB_CDEF, 8'hFF); step();
    idle(); wr(64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    rd(0, 64'h7FFF_FFF8); rd(1, BASE + (64'd1 << (DL + 3))); step();
    idle(); rd(0, 64'h8007_FFF8); rd(1, 64'h0); step();
    idle(); step();

    // Backpressure on port 1 for three cycles, then a streaming burst.
    idle(); rd_resp_ready[1] = 1'b0; rd(1, BASE + 64'd16); step();
    for (int c = 0; c < 3; c++) step();
    rd_resp_ready[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      rd(1, BASE + 64'(k * 8)); rd(0, BASE + 64'((8 - k) * 8)); step();
    end
    idle(); step();

    // Randomised mix of writes, reads and backpressure over words 0..7.
    for (int c = 0; c < 40; c++) begin
      idle();
      if ($urandom_range(1) == 1)
        wr(BASE + 64'($urandom_range(7) * 8), {$urandom, $urandom}, 8'($urandom));
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(3) != 0) rd(p, BASE + 64'($urandom_range(7) * 8));
        rd_resp_ready[p] = ($urandom_range(3) != 0);
      end
      step();
    end
    idle(); rd_resp_ready = '1;
    repeat (2) step();

    // Reset with responses pending; store must survive.
    idle(); rd(0, 64'h8000_0008); rd(1, 64'h8000_0010); step();
    reset = 1'b1;
    #1;
    check("mid_rst_vld", 64'(rd_resp_valid), 64'(0));
    check("mid_rst_wrdy", 64'(wr_ready), 64'(0));
    q0.delete();
    q1.delete();
    idle();
    @(negedge clk);
    step();
    reset = 1'b0;
    rd(0, 64'h8000_0008); rd(1, 64'h8000_0010); step();
    idle(); step();

    // Drain within a fixed cycle budget.
    for (int c = 0; c < 4; c++) if (q0.size() + q1.size() != 0) step();
    check("drain", 64'(q0.size() + q1.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
